axi_lite_to_native: RTL and testbench
=====================================

Name: axi_lite_to_native

Overview:
AXI4-Lite slave (responder) that accepts read and write transactions from an AXI4-Lite master and replays each as a single request on the native valid/ready memory interface used by the RISC-V core and its memories. It lets AXI-side masters (DMA, debug, interconnect) reach native-interface memories and peripherals. One transaction is outstanding at a time. Every access gets an AXI response: OKAY, SLVERR on timeout or native error, DECERR when the address is out of range.

Parameters:
BASE_ADDR, 32'h0000_0000, first decoded byte address.
SIZE_BYTES, 32'h0001_0000, decoded window size; accesses outside [BASE_ADDR, BASE_ADDR+SIZE_BYTES) get DECERR.
TIMEOUT_CYCLES, 255, maximum cycles mem_valid may wait for mem_ready; 0 disables the timeout.

Ports:
aclk  in  1  clock
reset  in  1  asynchronous, active-high reset
ar_addr  in  32  read address
ar_prot  in  3  ignored
ar_valid  in  1  read address valid
ar_ready  out  1  slave accepts read address
r_data  out  32  read data
r_resp  out  2  read response
r_valid  out  1  read data valid
r_ready  in  1  master accepts read data
aw_addr  in  32  write address
aw_prot  in  3  ignored
aw_valid  in  1  write address valid
aw_ready  out  1  slave accepts write address
w_data  in  32  write data
w_strb  in  4  byte enables
w_valid  in  1  write data valid
w_ready  out  1  slave accepts write data
b_resp  out  2  write response
b_valid  out  1  write response valid
b_ready  in  1  master accepts write response
mem_valid  out  1  native request valid
mem_rw  out  1  0 = read, 1 = write
mem_addr  out  32  native byte address
mem_wrdata  out  32  native write data
mem_wstrb  out  4  native byte enables
mem_ready  in  1  native request completed
mem_rdata  in  32  native read data, valid when mem_ready is high
mem_err  in  1  native error, sampled with mem_ready

Behaviour:
- Reset (async assert, sync release): state IDLE; aw_held and w_held = 0; prio_read = 1; timeout counter = 0.
- Reset values of outputs: mem_valid, r_valid, b_valid = 0; r_data, r_resp, b_resp, mem_addr, mem_wrdata, mem_wstrb, mem_rw = 0.
- States: IDLE, RD_REQ, RD_RESP, WR_REQ, WR_RESP.
- ar_ready = IDLE & !aw_held & !w_held & (prio_read | !(aw_valid | w_valid)).
- aw_ready = IDLE & !aw_held & !ar_grant. w_ready = IDLE & !w_held & !ar_grant.
- ar_grant = ar_ready & ar_valid. So AR and AW/W never handshake in the same cycle.
- Ready outputs have no combinational path from mem_* inputs.
- AW and W are captured independently, in any order or the same cycle; their held flags are set on capture.
- Once both are held, next state is WR_REQ.
- Read on AR handshake (cycle 0):
  - Latch ar_addr; go to RD_REQ.
  - mem_valid = 1 from cycle 1, mem_rw = 0, mem_wstrb = 0.
- In RD_REQ / WR_REQ, mem_valid and mem_addr/mem_wrdata/mem_wstrb/mem_rw stay stable until mem_ready.
- On mem_ready, the next cycle has:
  - mem_valid = 0.
  - Read: r_valid = 1, r_data = mem_rdata, r_resp = mem_err ? 2'b10 : 2'b00.
  - Write: b_valid = 1, b_resp likewise.
  - Minimum read latency AR handshake to r_valid: 2 cycles.
- r_valid/b_valid and data/resp are held until r_ready/b_ready; then IDLE.
- prio_read toggles after each completed transaction: 0 after a read, 1 after a write.
- Held flags clear on WR_REQ entry.
- Decode miss:
  - No native request issued; state goes directly to RD_RESP/WR_RESP the cycle after capture.
  - resp = 2'b11; r_data = 0.
- Timeout:
  - The counter counts cycles in REQ with mem_valid & !mem_ready.
  - At count == TIMEOUT_CYCLES: mem_valid drops, resp = 2'b10, r_data = 0, go to RESP.
  - A late mem_ready arriving in RESP/IDLE is ignored.
- mem_ready outside REQ states is ignored.
- Reset mid-transaction aborts it; no response is issued.

Decomposition:
- Package axi_lite_pkg holds:
  - Response constants: RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
  - State enum typedef.
  - ADDR_W = 32, DATA_W = 32.
- No sub-module is required. The address-range check is a single function in the package (addr_in_range).

Test Plan:
- Read at 32'h10 with mem_ready on cycle 1, mem_rdata = 32'hDEADBEEF -> r_valid at cycle 2, r_data = 32'hDEADBEEF, r_resp = 2'b00; mem_valid high exactly 1 cycle.
- W (32'h12345678, strb 4'b0011) 3 cycles before AW (32'h20) -> one mem request with mem_rw = 1, mem_addr = 32'h20, mem_wstrb = 4'b0011; b_resp = 00; b_valid held until b_ready rises 4 cycles later.
- ar_valid, aw_valid and w_valid asserted together after reset -> read served first (prio_read = 1), then write; a second simultaneous pair is served write-first.
- Read at BASE_ADDR + SIZE_BYTES -> mem_valid never asserts; r_resp = 2'b11, r_data = 0.
- mem_ready tied low with TIMEOUT_CYCLES = 4 -> mem_valid drops after 4 cycles; r_resp = 2'b10; a late mem_ready pulse is ignored.
- reset asserted while in WR_REQ -> mem_valid and b_valid go to 0 immediately; the next read completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite to native-interface bridge.
// Holds bus widths, AXI response encodings, the bridge state type and
// the address-window decode helper used by axi_lite_to_native.
package axi_lite_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_RESP = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_e;

  // True when addr lies in [base, base+size). The offset form avoids
  // overflow when base+size wraps past the top of the address space.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input logic [ADDR_W-1:0] base,
                                         input logic [ADDR_W-1:0] size);
    logic [ADDR_W-1:0] offset;
    offset = addr - base;
    return (addr >= base) && (offset < size);
  endfunction

endpackage

// File: rtl/axi_lite_to_native.sv
// AXI4-Lite slave that replays each read or write as one request on the
// native valid/ready memory interface. One transaction outstanding at a time.
//
// Ports:
//   aclk, reset            clock, asynchronous active-high reset
//   ar_* / r_*             AXI read address and read data channels
//   aw_* / w_* / b_*       AXI write address, write data, write response
//   mem_valid/rw/addr/
//   mem_wrdata/wstrb       native request (held stable until mem_ready)
//   mem_ready/rdata/err    native completion, read data and error flag
//
// Responses: OKAY, SLVERR on native error or timeout, DECERR outside the
// decoded window (no native request is issued in that case).
module axi_lite_to_native
  import axi_lite_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] SIZE_BYTES     = 32'h0001_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              aclk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic [2:0]        ar_prot,
  input  logic              ar_valid,
  output logic              ar_ready,
  output logic [DATA_W-1:0] r_data,
  output logic [1:0]        r_resp,
  output logic              r_valid,
  input  logic              r_ready,
  input  logic [ADDR_W-1:0] aw_addr,
  input  logic [2:0]        aw_prot,
  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic [DATA_W-1:0] w_data,
  input  logic [3:0]        w_strb,
  input  logic              w_valid,
  output logic              w_ready,
  output logic [1:0]        b_resp,
  output logic              b_valid,
  input  logic              b_ready,
  output logic              mem_valid,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wrdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err
);

  localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);
  localparam logic        TMO_EN    = (TIMEOUT_CYCLES != 0);

  state_e            state_q, state_d;
  logic              aw_held_q, aw_held_d;
  logic              w_held_q, w_held_d;
  logic              prio_read_q, prio_read_d;
  logic [31:0]       tmo_cnt_q, tmo_cnt_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wrdata_q, mem_wrdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic              r_valid_q, r_valid_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic [1:0]        r_resp_q, r_resp_d;
  logic              b_valid_q, b_valid_d;
  logic [1:0]        b_resp_q, b_resp_d;

  logic ar_ready_s, aw_ready_s, w_ready_s;
  logic ar_grant_s, aw_hs_s, w_hs_s;
  logic is_idle_s, in_req_s, req_is_rd_s;
  logic unused_prot_s;

  // Protection attributes carry no meaning on the native side.
  assign unused_prot_s = ^{ar_prot, aw_prot};

  // Ready generation depends only on state, held flags and AXI valids,
  // never on mem_* inputs. A pending read wins unless write priority is
  // active and the master is offering AW or W.
  assign is_idle_s  = (state_q == IDLE);
  assign ar_ready_s = is_idle_s & ~aw_held_q & ~w_held_q &
                      (prio_read_q | ~(aw_valid | w_valid));
  assign ar_grant_s = ar_ready_s & ar_valid;
  assign aw_ready_s = is_idle_s & ~aw_held_q & ~ar_grant_s;
  assign w_ready_s  = is_idle_s & ~w_held_q & ~ar_grant_s;
  assign aw_hs_s    = aw_ready_s & aw_valid;
  assign w_hs_s     = w_ready_s & w_valid;

  assign in_req_s    = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign req_is_rd_s = (state_q == RD_REQ);

  // Next-state and datapath computation for the bridge FSM.
  always_comb begin
    state_d      = state_q;
    aw_held_d    = aw_held_q;
    w_held_d     = w_held_q;
    prio_read_d  = prio_read_q;
    tmo_cnt_d    = tmo_cnt_q;
    mem_valid_d  = mem_valid_q;
    mem_rw_d     = mem_rw_q;
    mem_addr_d   = mem_addr_q;
    mem_wrdata_d = mem_wrdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    r_valid_d    = r_valid_q;
    r_data_d     = r_data_q;
    r_resp_d     = r_resp_q;
    b_valid_d    = b_valid_q;
    b_resp_d     = b_resp_q;

    case (state_q)
      IDLE: begin
        tmo_cnt_d = 32'd0;
        if (ar_grant_s) begin
          mem_addr_d  = ar_addr;
          mem_rw_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          if (addr_in_range(ar_addr, BASE_ADDR, SIZE_BYTES)) begin
            state_d     = RD_REQ;
            mem_valid_d = 1'b1;
          end else begin
            state_d   = RD_RESP;
            r_valid_d = 1'b1;
            r_resp_d  = RESP_DECERR;
            r_data_d  = '0;
          end
        end else begin
          // AW and W are captured independently; mem_addr/wrdata/wstrb
          // double as the holding registers since no read can start
          // while either half of a write is held.
          if (aw_hs_s) begin
            mem_addr_d = aw_addr;
            aw_held_d  = 1'b1;
          end else begin
            aw_held_d = aw_held_q;
          end
          if (w_hs_s) begin
            mem_wrdata_d = w_data;
            mem_wstrb_d  = w_strb;
            w_held_d     = 1'b1;
          end else begin
            w_held_d = w_held_q;
          end
          if (aw_held_d && w_held_d) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            mem_rw_d  = 1'b1;
            if (addr_in_range(mem_addr_d, BASE_ADDR, SIZE_BYTES)) begin
              state_d     = WR_REQ;
              mem_valid_d = 1'b1;
            end else begin
              state_d   = WR_RESP;
              b_valid_d = 1'b1;
              b_resp_d  = RESP_DECERR;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end

      RD_REQ, WR_REQ: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          tmo_cnt_d   = 32'd0;
          if (req_is_rd_s) begin
            state_d   = RD_RESP;
            r_valid_d = 1'b1;
            r_data_d  = mem_rdata;
            r_resp_d  = mem_err ? RESP_SLVERR : RESP_OKAY;
          end else begin
            state_d   = WR_RESP;
            b_valid_d = 1'b1;
            b_resp_d  = mem_err ? RESP_SLVERR : RESP_OKAY;
          end
        end else if (TMO_EN && ((tmo_cnt_q + 32'd1) == TMO_LIMIT)) begin
          // Abandon the native request; a late mem_ready is ignored
          // because it is only looked at in the REQ states.
          mem_valid_d = 1'b0;
          tmo_cnt_d   = 32'd0;
          if (req_is_rd_s) begin
            state_d   = RD_RESP;
            r_valid_d = 1'b1;
            r_data_d  = '0;
            r_resp_d  = RESP_SLVERR;
          end else begin
            state_d   = WR_RESP;
            b_valid_d = 1'b1;
            b_resp_d  = RESP_SLVERR;
          end
        end else begin
          tmo_cnt_d = TMO_EN ? (tmo_cnt_q + 32'd1) : 32'd0;
        end
      end

      RD_RESP: begin
        if (r_ready) begin
          r_valid_d   = 1'b0;
          prio_read_d = 1'b0;
          state_d     = IDLE;
        end else begin
          r_valid_d = 1'b1;
        end
      end

      WR_RESP: begin
        if (b_ready) begin
          b_valid_d   = 1'b0;
          prio_read_d = 1'b1;
          state_d     = IDLE;
        end else begin
          b_valid_d = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      prio_read_q  <= 1'b1;
      tmo_cnt_q    <= 32'd0;
      mem_valid_q  <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wrdata_q <= '0;
      mem_wstrb_q  <= 4'b0000;
      r_valid_q    <= 1'b0;
      r_data_q     <= '0;
      r_resp_q     <= 2'b00;
      b_valid_q    <= 1'b0;
      b_resp_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      aw_held_q    <= aw_held_d;
      w_held_q     <= w_held_d;
      prio_read_q  <= prio_read_d;
      tmo_cnt_q    <= tmo_cnt_d;
      mem_valid_q  <= mem_valid_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wrdata_q <= mem_wrdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      r_valid_q    <= r_valid_d;
      r_data_q     <= r_data_d;
      r_resp_q     <= r_resp_d;
      b_valid_q    <= b_valid_d;
      b_resp_q     <= b_resp_d;
    end
  end

  assign ar_ready   = ar_ready_s;
  assign aw_ready   = aw_ready_s;
  assign w_ready    = w_ready_s;
  assign r_valid    = r_valid_q;
  assign r_data     = r_data_q;
  assign r_resp     = r_resp_q;
  assign b_valid    = b_valid_q;
  assign b_resp     = b_resp_q;
  assign mem_valid  = mem_valid_q;
  assign mem_rw     = mem_rw_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wrdata = mem_wrdata_q;
  assign mem_wstrb  = mem_wstrb_q;

endmodule

// File: tb/tb_axi_lite_to_native.sv
// Self-checking bench for axi_lite_to_native: AXI master tasks push the
// expected native requests and AXI responses into queues; a native
// responder and R/B monitors pop and compare them as the DUT produces them.
module tb_axi_lite_to_native;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] SIZE = 32'h0001_0000;

  logic        aclk;
  logic        reset;
  logic [31:0] ar_addr;
  logic [2:0]  ar_prot;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_valid;
  logic        r_ready;
  logic [31:0] aw_addr;
  logic [2:0]  aw_prot;
  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_valid;
  logic        w_ready;
  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready;
  logic        mem_valid;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wrdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_err;

  axi_lite_to_native #(
    .BASE_ADDR(BASE), .SIZE_BYTES(SIZE), .TIMEOUT_CYCLES(4)
  ) dut (
    .aclk(aclk), .reset(reset),
    .ar_addr(ar_addr), .ar_prot(ar_prot), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
    .aw_addr(aw_addr), .aw_prot(aw_prot), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wrdata(mem_wrdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  // {rw, addr, wdata, wstrb}
  logic [68:0] exp_n_q[$];
  // {resp, data}
  logic [33:0] exp_r_q[$];
  logic [1:0]  exp_b_q[$];

  logic tie_low    = 1'b0;
  logic force_pulse = 1'b0;
  logic err_flag   = 1'b0;
  int   mv_cycles  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_pattern(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
    return (a << 4) ^ 32'h5A5A_0000;
  endfunction

  task automatic wait_cyc();
    @(posedge aclk);
    #1;
  endtask

  // Native-side responder: answers in the first cycle mem_valid is seen
  // unless tied low, logs each new request and checks it is held stable.
  initial begin
    logic        prev_mv;
    logic [68:0] e;
    logic [31:0] cur_addr;
    prev_mv   = 1'b0;
    cur_addr  = 32'h0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    mem_err   = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      if (mem_valid && !prev_mv) begin
        cur_addr = mem_addr;
        if (exp_n_q.size() == 0) begin
          check_eq("native_unexpected", {31'h0, mem_valid}, 32'h0);
        end else begin
          e = exp_n_q.pop_front();
          check_eq("native_rw", {31'h0, mem_rw}, {31'h0, e[68]});
          check_eq("native_addr", mem_addr, e[67:36]);
          check_eq("native_wstrb", {28'h0, mem_wstrb}, {28'h0, e[3:0]});
          if (e[68]) check_eq("native_wdata", mem_wrdata, e[35:4]);
        end
      end else if (mem_valid) begin
        check_eq("native_addr_stable", mem_addr, cur_addr);
      end
      prev_mv = mem_valid;
      if (mem_valid) mv_cycles++;
      if (force_pulse) begin
        mem_ready   = 1'b1;
        mem_rdata   = 32'hBAD0_BAD0;
        mem_err     = 1'b1;
        force_pulse = 1'b0;
      end else if (mem_valid && !tie_low && !mem_ready) begin
        mem_ready = 1'b1;
        mem_rdata = rd_pattern(mem_addr);
        mem_err   = err_flag;
      end else begin
        mem_ready = 1'b0;
        mem_err   = 1'b0;
      end
    end
  end

  // R and B channel monitors: compare on the handshake cycle.
  initial begin
    logic [33:0] e;
    forever begin
      @(posedge aclk);
      #2;
      if (r_valid && r_ready) begin
        if (exp_r_q.size() == 0) begin
          check_eq("r_unexpected", {31'h0, r_valid}, 32'h0);
        end else begin
          e = exp_r_q.pop_front();
          check_eq("r_data", r_data, e[31:0]);
          check_eq("r_resp", {30'h0, r_resp}, {30'h0, e[33:32]});
        end
      end
      if (b_valid && b_ready) begin
        if (exp_b_q.size() == 0) begin
          check_eq("b_unexpected", {31'h0, b_valid}, 32'h0);
        end else begin
          check_eq("b_resp", {30'h0, b_resp}, {30'h0, exp_b_q.pop_front()});
        end
      end
    end
  end

  task automatic send_ar(input logic [31:0] a);
    logic hs;
    hs = 1'b0;
    ar_addr  = a;
    ar_valid = 1'b1;
    for (int i = 0; i < 200 && !hs; i++) begin
      #1;
      hs = ar_ready;
      wait_cyc();
    end
    ar_valid = 1'b0;
    check_eq("ar_handshake", {31'h0, hs}, 32'h1);
  endtask

  task automatic send_aw(input logic [31:0] a);
    logic hs;
    hs = 1'b0;
    aw_addr  = a;
    aw_valid = 1'b1;
    for (int i = 0; i < 200 && !hs; i++) begin
      #1;
      hs = aw_ready;
      wait_cyc();
    end
    aw_valid = 1'b0;
    check_eq("aw_handshake", {31'h0, hs}, 32'h1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    logic hs;
    hs = 1'b0;
    w_data  = d;
    w_strb  = s;
    w_valid = 1'b1;
    for (int i = 0; i < 200 && !hs; i++) begin
      #1;
      hs = w_ready;
      wait_cyc();
    end
    w_valid = 1'b0;
    check_eq("w_handshake", {31'h0, hs}, 32'h1);
  endtask

  task automatic exp_read(input logic [31:0] a, input logic [1:0] resp,
                          input logic [31:0] d, input logic native);
    if (native) exp_n_q.push_back({1'b0, a, 32'h0, 4'h0});
    exp_r_q.push_back({resp, d});
  endtask

  task automatic exp_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] resp,
                           input logic native);
    if (native) exp_n_q.push_back({1'b1, a, d, s});
    exp_b_q.push_back(resp);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (exp_n_q.size() == 0 && exp_r_q.size() == 0 && exp_b_q.size() == 0) break;
      wait_cyc();
    end
    check_eq({tag, "_native_left"}, exp_n_q.size(), 32'd0);
    check_eq({tag, "_r_left"}, exp_r_q.size(), 32'd0);
    check_eq({tag, "_b_left"}, exp_b_q.size(), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    ar_addr  = 32'h0; ar_prot = 3'b000; ar_valid = 1'b0;
    aw_addr  = 32'h0; aw_prot = 3'b000; aw_valid = 1'b0;
    w_data   = 32'h0; w_strb  = 4'h0;   w_valid  = 1'b0;
    r_ready  = 1'b1;  b_ready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    reset = 1'b0;
    wait_cyc();

    // Reset state.
    check_eq("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
    check_eq("rst_r_valid", {31'h0, r_valid}, 32'h0);
    check_eq("rst_b_valid", {31'h0, b_valid}, 32'h0);
    check_eq("rst_r_data", r_data, 32'h0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_rw", {31'h0, mem_rw}, 32'h0);
    check_eq("rst_ar_ready", {31'h0, ar_ready}, 32'h1);
    check_eq("rst_aw_ready", {31'h0, aw_ready}, 32'h1);

    // Simultaneous AR/AW/W after reset: read goes first.
    exp_read(32'h30, 2'b00, rd_pattern(32'h30), 1'b1);
    exp_write(32'h34, 32'hA1B2_C3D4, 4'hF, 2'b00, 1'b1);
    fork
      send_ar(32'h30);
      send_aw(32'h34);
      send_w(32'hA1B2_C3D4, 4'hF);
    join
    drain("prio_rd");

    // Single read at 0x10 with immediate mem_ready; 2-cycle latency.
    mv_cycles = 0;
    exp_read(32'h10, 2'b00, 32'hDEAD_BEEF, 1'b1);
    send_ar(32'h10);
    check_eq("lat_c1_mem_valid", {31'h0, mem_valid}, 32'h1);
    check_eq("lat_c1_r_valid", {31'h0, r_valid}, 32'h0);
    wait_cyc();
    check_eq("lat_c2_r_valid", {31'h0, r_valid}, 32'h1);
    check_eq("lat_c2_mem_valid", {31'h0, mem_valid}, 32'h0);
    drain("rd10");
    check_eq("rd10_mv_cycles", mv_cycles, 32'd1);

    // Last completion was a read, so the next simultaneous set goes write-first.
    exp_write(32'h50, 32'h0BAD_F00D, 4'b1100, 2'b00, 1'b1);
    exp_read(32'h54, 2'b00, rd_pattern(32'h54), 1'b1);
    fork
      send_ar(32'h54);
      send_aw(32'h50);
      send_w(32'h0BAD_F00D, 4'b1100);
    join
    drain("prio_wr");

    // W three cycles ahead of AW, B held until b_ready rises 4 cycles later.
    b_ready = 1'b0;
    exp_write(32'h20, 32'h1234_5678, 4'b0011, 2'b00, 1'b1);
    fork
      send_w(32'h1234_5678, 4'b0011);
      begin
        repeat (3) wait_cyc();
        send_aw(32'h20);
      end
    join
    for (int i = 0; i < 20 && !b_valid; i++) wait_cyc();
    check_eq("wr_b_valid_rise", {31'h0, b_valid}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      wait_cyc();
      check_eq("wr_b_valid_hold", {31'h0, b_valid}, 32'h1);
    end
    b_ready = 1'b1;
    drain("wr20");

    // Decode misses: first address past the window, read and write.
    mv_cycles = 0;
    exp_read(BASE + SIZE, 2'b11, 32'h0, 1'b0);
    send_ar(BASE + SIZE);
    exp_write(32'h0002_0000, 32'hFFFF_FFFF, 4'hF, 2'b11, 1'b0);
    fork
      send_aw(32'h0002_0000);
      send_w(32'hFFFF_FFFF, 4'hF);
    join
    drain("decerr");
    check_eq("decerr_mv_cycles", mv_cycles, 32'd0);

    // Native error on a read -> SLVERR with the returned data.
    err_flag = 1'b1;
    exp_read(32'h44, 2'b10, rd_pattern(32'h44), 1'b1);
    send_ar(32'h44);
    drain("nerr");
    err_flag = 1'b0;

    // Timeout with mem_ready tied low; late pulses must be ignored.
    tie_low   = 1'b1;
    r_ready   = 1'b0;
    mv_cycles = 0;
    exp_read(32'h40, 2'b10, 32'h0, 1'b1);
    send_ar(32'h40);
    for (int i = 0; i < 20 && !r_valid; i++) wait_cyc();
    check_eq("tmo_r_valid", {31'h0, r_valid}, 32'h1);
    check_eq("tmo_mv_cycles", mv_cycles, 32'd4);
    check_eq("tmo_mem_valid", {31'h0, mem_valid}, 32'h0);
    force_pulse = 1'b1;
    repeat (2) wait_cyc();
    check_eq("late_rdy_r_valid", {31'h0, r_valid}, 32'h1);
    check_eq("late_rdy_r_data", r_data, 32'h0);
    check_eq("late_rdy_r_resp", {30'h0, r_resp}, 32'h2);
    tie_low = 1'b0;
    r_ready = 1'b1;
    drain("tmo");
    force_pulse = 1'b1;
    repeat (3) wait_cyc();
    check_eq("idle_rdy_r_valid", {31'h0, r_valid}, 32'h0);
    check_eq("idle_rdy_b_valid", {31'h0, b_valid}, 32'h0);
    check_eq("idle_rdy_mem_valid", {31'h0, mem_valid}, 32'h0);

    // Reset while in WR_REQ aborts the write without a response.
    tie_low = 1'b1;
    exp_n_q.push_back({1'b1, 32'h60, 32'h7777_8888, 4'hF});
    fork
      send_aw(32'h60);
      send_w(32'h7777_8888, 4'hF);
    join
    wait_cyc();
    check_eq("wrreq_mem_valid", {31'h0, mem_valid}, 32'h1);
    reset = 1'b1;
    #1;
    check_eq("abort_mem_valid", {31'h0, mem_valid}, 32'h0);
    check_eq("abort_b_valid", {31'h0, b_valid}, 32'h0);
    tie_low = 1'b0;
    wait_cyc();
    reset = 1'b0;
    wait_cyc();
    exp_read(32'h70, 2'b00, rd_pattern(32'h70), 1'b1);
    send_ar(32'h70);
    drain("post_rst");
    repeat (3) wait_cyc();
    check_eq("post_rst_b_valid", {31'h0, b_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
